// File: rtl/prog_lut_sweep.sv
// K-input programmable lookup table with a registered, tri-stateable output.
// The table loads serially; a sweep engine streams every entry and counts the ones.
module prog_lut_sweep #(
    parameter int              K    = 4,
    parameter logic [2**K-1:0] INIT = 16'h55F2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [K-1:0] x_i,
    input  logic         en_i,
    input  logic         cfg_load_i,
    input  logic         cfg_bit_i,
    input  logic         sweep_start_i,
    output wire          f_o,
    output logic         y_o,
    output logic         sweep_busy_o,
    output logic         sweep_valid_o,
    output logic [K-1:0] sweep_code_o,
    output logic         sweep_done_o,
    output logic [K:0]   ones_count_o
);

    localparam int            DEPTH   = 2**K;
    localparam logic [K-1:0]  CNT_MAX = '1;
    localparam logic [K-1:0]  CNT_ONE = {{(K-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [DEPTH-1:0]   tt_q;
    logic [DEPTH-1:0]   tt_d;
    logic               y_q;
    logic               en_q;
    logic [K-1:0]       cnt_q;
    logic [K-1:0]       cnt_d;
    logic               valid_q;
    logic [K-1:0]       code_q;
    logic               done_q;
    logic [K:0]         ones_q;
    logic [K:0]         ones_d;

    // New bits enter at the top, so the first bit shifted lands in entry 0 after a full load.
    always_comb begin
        tt_d   = {cfg_bit_i, tt_q[DEPTH-1:1]};
        cnt_d  = cnt_q + CNT_ONE;
        ones_d = ones_q + {{K{1'b0}}, tt_q[cnt_q]};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            tt_q    <= INIT;
            y_q     <= 1'b0;
            en_q    <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= '0;
            done_q  <= 1'b0;
            ones_q  <= '0;
        end else begin
            en_q <= en_i;
            case (state_q)
                S_IDLE: begin
                    y_q     <= tt_q[x_i];
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (cfg_load_i) begin
                        tt_q <= tt_d;
                    end
                    if (sweep_start_i) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        ones_q  <= '0;
                    end
                end
                S_RUN: begin
                    y_q     <= tt_q[cnt_q];
                    code_q  <= cnt_q;
                    valid_q <= 1'b1;
                    ones_q  <= ones_d;
                    cnt_q   <= cnt_d;
                    if (cnt_q == CNT_MAX) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    valid_q <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign f_o           = en_q ? y_q : 1'bz;
    assign y_o           = y_q;
    assign sweep_busy_o  = (state_q != S_IDLE);
    assign sweep_valid_o = valid_q;
    assign sweep_code_o  = code_q;
    assign sweep_done_o  = done_q;
    assign ones_count_o  = ones_q;

endmodule

// File: tb/tb_prog_lut_sweep.sv
// Scoreboard bench for prog_lut_sweep: stimulus pushes expected lookups and sweep beats,
// a monitor pops and compares them whenever the DUT presents a result.
module tb_prog_lut_sweep;

    localparam int          K     = 4;
    localparam logic [15:0] INITV = 16'h55F2;

    typedef struct {logic y; logic en;} norm_t;
    typedef struct {logic [3:0] code; logic y; logic en;} beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] x = '0;
    logic       en = 1'b0;
    logic       cfg_load = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       sweep_start = 1'b0;
    wire        f_w;
    logic       y_w;
    logic       busy_w;
    logic       valid_w;
    logic [3:0] code_w;
    logic       done_w;
    logic [4:0] ones_w;

    int n_total = 0;
    int n_pass  = 0;

    logic [15:0] m_tt = INITV;
    norm_t       q_norm[$];
    beat_t       q_sweep[$];
    logic [4:0]  q_ones[$];

    prog_lut_sweep #(.K(K), .INIT(INITV)) dut (
        .clk_i(clk), .rst_i(rst), .x_i(x), .en_i(en),
        .cfg_load_i(cfg_load), .cfg_bit_i(cfg_bit), .sweep_start_i(sweep_start),
        .f_o(f_w), .y_o(y_w), .sweep_busy_o(busy_w), .sweep_valid_o(valid_w),
        .sweep_code_o(code_w), .sweep_done_o(done_w), .ones_count_o(ones_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Output f: driven value when enabled, never a driven 1 when disabled.
    task automatic chk_f(input string name, input logic exp_en, input logic exp_y);
        if (exp_en) chk(name, {31'b0, f_w}, {31'b0, exp_y});
        else        chk({name, "_hiz"}, {31'b0, (f_w === 1'b1)}, 32'd0);
    endtask

    // Monitor: consumes expected results as the DUT presents them.
    initial begin
        norm_t nt;
        beat_t bt;
        forever begin
            @(posedge clk); #1;
            if (q_norm.size() > 0) begin
                nt = q_norm.pop_front();
                chk("lookup_y", {31'b0, y_w}, {31'b0, nt.y});
                chk_f("lookup_f", nt.en, nt.y);
            end
            if (valid_w) begin
                chk("beat_expected", {31'b0, (q_sweep.size() > 0)}, 32'd1);
                if (q_sweep.size() > 0) begin
                    bt = q_sweep.pop_front();
                    chk("beat_code", {28'b0, code_w}, {28'b0, bt.code});
                    chk("beat_y", {31'b0, y_w}, {31'b0, bt.y});
                    chk_f("beat_f", bt.en, bt.y);
                end
            end
            if (done_w) begin
                chk("done_all_beats", q_sweep.size(), 32'd0);
                chk("done_expected", {31'b0, (q_ones.size() > 0)}, 32'd1);
                if (q_ones.size() > 0) chk("ones_count", {27'b0, ones_w}, {27'b0, q_ones.pop_front()});
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; sweep_start = 1'b0; cfg_load = 1'b0;
        q_norm.delete(); q_sweep.delete(); q_ones.delete();
        @(posedge clk); #1;
        chk("rst_y", {31'b0, y_w}, 32'd0);
        chk_f("rst_f", 1'b0, 1'b0);
        chk("rst_busy", {31'b0, busy_w}, 32'd0);
        chk("rst_valid", {31'b0, valid_w}, 32'd0);
        chk("rst_code", {28'b0, code_w}, 32'd0);
        chk("rst_done", {31'b0, done_w}, 32'd0);
        chk("rst_ones", {27'b0, ones_w}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_tt = INITV;
    endtask

    task automatic lookup(input logic [3:0] xv, input logic ev);
        @(negedge clk);
        x = xv; en = ev;
        q_norm.push_back('{y: m_tt[xv], en: ev});
    endtask

    // Full serial load: bit i of v is sent i-th, so v becomes the table.
    task automatic load_tt(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            cfg_load = 1'b1; cfg_bit = v[i];
        end
        @(negedge clk);
        cfg_load = 1'b0;
        m_tt = v;
    endtask

    task automatic push_sweep();
        for (int i = 0; i < 16; i++) q_sweep.push_back('{code: 4'(i), y: m_tt[i], en: en});
        q_ones.push_back(5'($countones(m_tt)));
    endtask

    // guard=1 hammers cfg_load/sweep_start while busy; both must be ignored.
    task automatic run_sweep(input bit guard);
        int  n;
        bit  seen;
        @(negedge clk);
        sweep_start = 1'b1; cfg_load = 1'b0;
        push_sweep();
        @(posedge clk); #1;
        chk("busy_rise", {31'b0, busy_w}, 32'd1);
        chk("valid_lag", {31'b0, valid_w}, 32'd0);
        n = 0; seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            sweep_start = guard && (n % 5 == 2);
            cfg_load    = guard;
            cfg_bit     = 1'b0;
            @(posedge clk); #1;
            n++;
            if (done_w) seen = 1;
        end
        sweep_start = 1'b0; cfg_load = 1'b0;
        chk("done_cycle", n, 32'd17);
        chk("busy_at_done", {31'b0, busy_w}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();

        lookup(4'b0001, 1'b1);
        lookup(4'b0011, 1'b1);
        lookup(4'b0011, 1'b0);
        for (int i = 0; i < 16; i++) lookup(4'(i), 1'b1);

        run_sweep(0);

        load_tt(16'hFFFF);
        for (int i = 0; i < 16; i++) lookup(4'(i), 1'b1);
        run_sweep(0);
        load_tt(16'h5555);
        lookup(4'd0, 1'b1);
        lookup(4'd1, 1'b1);

        do_reset();
        lookup(4'd0, 1'b1);
        run_sweep(1);
        for (int i = 0; i < 16; i++) lookup(4'(i), 1'b1);

        // Reset in the middle of a sweep, at beat 5.
        @(negedge clk);
        sweep_start = 1'b1;
        push_sweep();
        @(negedge clk);
        sweep_start = 1'b0;
        n = 0;
        while (!(valid_w && code_w == 4'd5) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_beat5", {31'b0, (n < 40)}, 32'd1);
        do_reset();

        load_tt(16'h0000);
        lookup(4'd1, 1'b1);
        do_reset();
        lookup(4'd1, 1'b1);

        for (int r = 0; r < 6; r++) begin
            load_tt(16'($urandom));
            for (int j = 0; j < 20; j++) lookup(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            @(negedge clk);
            en = 1'($urandom_range(0, 1));
            run_sweep(1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("queues_drained", q_norm.size() + q_sweep.size() + q_ones.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
